// File: rtl/ntt_bf_addsub.sv
// ntt_bf_addsub: CT butterfly stage, delays a to meet the mo_mul product p, emits (a+p) and (a-p) mod Q.
// Define NTT_BF_HALVE_EN to append a divide-by-2 mod Q output stage for INTT scaling.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif
`ifndef MUL_STAGE_CNT
`define MUL_STAGE_CNT 3
`endif
module ntt_bf_addsub #(
  parameter int DATA_WIDTH    = `DATA_WIDTH,
  parameter int Q             = `Q,
  parameter int MUL_STAGE_CNT = `MUL_STAGE_CNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic                  last_in,
  input  logic [DATA_WIDTH-1:0] p_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic [DATA_WIDTH-1:0] diff_out,
  output logic                  last_out,
  output logic                  range_err
);
  localparam int DW = DATA_WIDTH;
  localparam int N = MUL_STAGE_CNT;
  localparam logic [DW:0] QW = Q[DW:0];
  logic [DW-1:0] a_dl, sum_d, diff_d, s1_q, d1_q;
  logic v_dl, l_dl, v1_q, l1_q, err_q, err_d;
  logic [DW:0] s, d;
  generate
    if (N == 0) begin : g_nodly
      assign a_dl = a_in;
      assign v_dl = valid_in;
      assign l_dl = last_in & valid_in;
    end else begin : g_dly
      logic [DW-1:0] a_q [N];
      logic [N-1:0] v_q, l_q;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          a_q <= '{default: '0};
          v_q <= '0;
          l_q <= '0;
        end else begin
          a_q[0] <= a_in;
          v_q[0] <= valid_in;
          l_q[0] <= last_in & valid_in;
          for (int i = 1; i < N; i++) begin
            a_q[i] <= a_q[i-1];
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
          end
        end
      assign a_dl = a_q[N-1];
      assign v_dl = v_q[N-1];
      assign l_dl = l_q[N-1];
    end
  endgenerate
  // d is signed in effect: bit DW set means a < p
  always_comb begin
    s = {1'b0, a_dl} + {1'b0, p_in};
    d = {1'b0, a_dl} - {1'b0, p_in};
    sum_d = DW'(s >= QW ? s - QW : s);
    diff_d = DW'(d[DW] ? d + QW : d);
    err_d = err_q | (valid_in && {1'b0, a_in} >= QW) | (v_dl && {1'b0, p_in} >= QW);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      s1_q <= '0;
      d1_q <= '0;
      err_q <= 1'b0;
    end else begin
      v1_q <= v_dl;
      l1_q <= v_dl & l_dl;
      err_q <= err_d;
      if (v_dl) begin
        s1_q <= sum_d;
        d1_q <= diff_d;
      end
    end
  assign range_err = err_q;
`ifdef NTT_BF_HALVE_EN
  function automatic logic [DW-1:0] halve(input logic [DW-1:0] x);
    logic [DW:0] t;
    t = {1'b0, x} + (x[0] ? QW : '0);
    return DW'(t >> 1);
  endfunction
  logic v2_q, l2_q;
  logic [DW-1:0] s2_q, d2_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v2_q <= 1'b0;
      l2_q <= 1'b0;
      s2_q <= '0;
      d2_q <= '0;
    end else begin
      v2_q <= v1_q;
      l2_q <= l1_q;
      if (v1_q) begin
        s2_q <= halve(s1_q);
        d2_q <= halve(d1_q);
      end
    end
  assign valid_out = v2_q;
  assign last_out = l2_q;
  assign sum_out = s2_q;
  assign diff_out = d2_q;
`else
  assign valid_out = v1_q;
  assign last_out = l1_q;
  assign sum_out = s1_q;
  assign diff_out = d1_q;
`endif
endmodule
